// File: rtl/camera_capture_stream.sv
// Camera pixel receive path: oversamples the sensor bus in clkMain, assembles
// multi-byte pixels, crops them and queues {sof, eol, pixel} in a small FIFO.
module camera_capture_stream #(
    parameter int DATA_W          = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int BYTE_ORDER      = 0,
    parameter int COL_W           = 10,
    parameter int ROW_W           = 9,
    parameter int FIFO_AW         = 3
) (
    input  logic                              clkMain,
    input  logic                              rstMain,
    input  logic                              en_i,
    input  logic                              ca_pclk,
    input  logic                              ca_href,
    input  logic                              ca_vsync,
    input  logic [DATA_W-1:0]                 ca_data,
    input  logic [COL_W-1:0]                  crop_x0_i,
    input  logic [COL_W-1:0]                  crop_x1_i,
    input  logic [ROW_W-1:0]                  crop_y0_i,
    input  logic [ROW_W-1:0]                  crop_y1_i,
    output logic [DATA_W*BYTES_PER_PIXEL-1:0] pixel_o,
    output logic                              pixel_sof_o,
    output logic                              pixel_eol_o,
    output logic                              pixel_valid_o,
    input  logic                              pixel_ready_i,
    output logic                              frame_valid_o,
    output logic [15:0]                       frame_count_o,
    output logic                              overflow_o,
    output logic [FIFO_AW:0]                  fifo_level_o
);

    localparam int PIX_W   = DATA_W * BYTES_PER_PIXEL;
    localparam int ENTRY_W = PIX_W + 2;
    localparam int DEPTH_I = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH     = DEPTH_I[FIFO_AW:0];
    localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [COL_W-1:0] COL_MAX   = '1;
    localparam logic [ROW_W-1:0] ROW_MAX   = '1;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

    // Bit order in the sync chain: {vsync, href, pclk}
    logic [2:0]        sync1_q, sync2_q, prev_q;
    logic [DATA_W-1:0] data1_q, data2_q;

    state_t            state_q, state_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              sof_arm_q, sof_arm_d;
    logic [BYTES_PER_PIXEL-1:0][DATA_W-1:0] pix_q, pix_d;
    logic              wr_q, wr_d;
    logic [ENTRY_W-1:0] wr_entry_q, wr_entry_d;

    logic [ENTRY_W-1:0] mem_q [DEPTH_I];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic pclk_rise, href_fall, vsync_fall, vsync_rise;
    logic enter_active, in_window, accept, pop, drop;
    logic [1:0] slot;
    logic [ENTRY_W-1:0] head;

    assign pclk_rise  =  sync2_q[0] & ~prev_q[0];
    assign href_fall  = ~sync2_q[1] &  prev_q[1];
    assign vsync_fall = ~sync2_q[2] &  prev_q[2];
    assign vsync_rise =  sync2_q[2] & ~prev_q[2];

    assign in_window = (col_q >= crop_x0_i) && (col_q <= crop_x1_i) &&
                       (row_q >= crop_y0_i) && (row_q <= crop_y1_i);
    assign slot = (BYTE_ORDER != 0) ? byte_cnt_q : (LAST_BYTE - byte_cnt_q);

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        enter_active = 1'b0;
        unique case (state_q)
            IDLE:     if (en_i) state_d = WAIT_SOF;
            WAIT_SOF: if (vsync_fall) begin
                state_d      = ACTIVE;
                enter_active = 1'b1;
            end
            ACTIVE:   if (vsync_rise) begin
                state_d     = WAIT_SOF;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            default:  state_d = IDLE;
        endcase
        // Disable abandons any frame in progress without counting it
        if (!en_i) begin
            state_d      = IDLE;
            frame_cnt_d  = frame_cnt_q;
            enter_active = 1'b0;
        end
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        byte_cnt_d = byte_cnt_q;
        sof_arm_d  = sof_arm_q;
        pix_d      = pix_q;
        wr_d       = 1'b0;
        wr_entry_d = wr_entry_q;
        if (state_q == ACTIVE) begin
            if (pclk_rise && sync2_q[1]) begin
                for (int b = 0; b < BYTES_PER_PIXEL; b++)
                    if (slot == 2'(b)) pix_d[b] = data2_q;
                if (byte_cnt_q == LAST_BYTE) begin
                    byte_cnt_d = 2'd0;
                    if (col_q != COL_MAX) col_d = col_q + 1'b1;
                    if (in_window) begin
                        wr_d       = 1'b1;
                        wr_entry_d = {sof_arm_q, (col_q == crop_x1_i), pix_d};
                        sof_arm_d  = 1'b0;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            // Line end drops any half-assembled pixel
            if (href_fall) begin
                byte_cnt_d = 2'd0;
                col_d      = '0;
                if (row_q != ROW_MAX) row_d = row_q + 1'b1;
            end
        end
        if (enter_active) begin
            col_d      = '0;
            row_d      = '0;
            byte_cnt_d = 2'd0;
            sof_arm_d  = 1'b1;
        end
    end

    assign pop    = pixel_valid_o & pixel_ready_i;
    assign accept = wr_q & ((count_q != DEPTH) | pop);
    assign drop   = wr_q & (count_q == DEPTH) & ~pop;

    always_comb begin
        count_d = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (drop)         overflow_d = 1'b1;
        if (enter_active) overflow_d = 1'b0;
    end

    always_ff @(posedge clkMain or negedge rstMain) begin
        if (!rstMain) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            state_q    <= IDLE;
            frame_cnt_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            byte_cnt_q <= '0;
            sof_arm_q  <= 1'b0;
            wr_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= {ca_vsync, ca_href, ca_pclk};
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            frame_cnt_q <= frame_cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            byte_cnt_q <= byte_cnt_d;
            sof_arm_q  <= sof_arm_d;
            wr_q       <= wr_d;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Data-only storage; validity is carried by the reset control state
    always_ff @(posedge clkMain) begin
        data1_q    <= ca_data;
        data2_q    <= data1_q;
        pix_q      <= pix_d;
        wr_entry_q <= wr_entry_d;
        if (accept) mem_q[wr_ptr_q] <= wr_entry_q;
    end

    assign head          = mem_q[rd_ptr_q];
    assign pixel_valid_o = (count_q != '0);
    assign pixel_o       = pixel_valid_o ? head[PIX_W-1:0] : '0;
    assign pixel_sof_o   = pixel_valid_o & head[PIX_W+1];
    assign pixel_eol_o   = pixel_valid_o & head[PIX_W];
    assign frame_valid_o = (state_q == ACTIVE);
    assign frame_count_o = frame_cnt_q;
    assign overflow_o    = overflow_q;
    assign fifo_level_o  = count_q;

endmodule
